// File: rtl/clk_gate_pkg.sv
// clk_gate_pkg: shared definitions for the gated-clock controller.
//   gate_state_t : controller state, encoding visible on oState
//                  (RUN=0, DRAIN=1, STOPPED=2, WAKE=3)
//   DEF_*        : default timing constants used as parameter defaults
package clk_gate_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_STOPPED = 2'd2,
        ST_WAKE    = 2'd3
    } gate_state_t;

    localparam int unsigned DEF_IDLE_CYCLES   = 16;
    localparam int unsigned DEF_WAKE_CYCLES   = 8;
    localparam int unsigned DEF_DRAIN_TIMEOUT = 1024;
    localparam int unsigned DEF_CNT_W         = 16;

    // Terminal-count value for a counter that must observe n cycles:
    // the counter starts at 0, so the last cycle is seen at n-1.
    function automatic int unsigned term_of(input int unsigned n);
        return (n == 0) ? 0 : n - 1;
    endfunction

endpackage

// File: rtl/clk_gate_ctrl_sat_counter.sv
// sat_counter: CNT_W-bit up counter with synchronous clear and a
// terminal-count compare.
//   clk         : clock
//   rst         : synchronous active-high reset (count -> 0)
//   clr         : synchronous clear (count -> 0), wins over inc
//   inc         : increment by one; holds at all-ones instead of wrapping
//   terminal    : compare value
//   at_terminal : high while count == terminal (unsigned compare)
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] terminal,
    output logic             at_terminal
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign at_terminal = (count == terminal);

endmodule

// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: owns the CE input of a BUFGCE-style gated clock buffer.
// Gates the clock on a stop request once the downstream domain has been
// idle for IDLE_CYCLES consecutive cycles (aborting after DRAIN_TIMEOUT
// cycles), and ungates it on a start request, acknowledging only after
// the clock has run for WAKE_CYCLES cycles.
//   iClock    : ungated system clock
//   iReset    : synchronous active-high reset
//   iStopReq  : level stop request, held until oStopAck
//   iStartReq : level start request, held until oStartAck
//   iIdle     : downstream idle (synchronous to iClock)
//   oClkEn    : registered clock enable, 1 = clock runs
//   oStopAck  : one-cycle pulse when gating completes
//   oStartAck : one-cycle pulse when the wake period completes
//   oTimeout  : one-cycle pulse when a drain is aborted
//   oState    : current state (RUN=0, DRAIN=1, STOPPED=2, WAKE=3)
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES   = DEF_IDLE_CYCLES,
    parameter int unsigned WAKE_CYCLES   = DEF_WAKE_CYCLES,
    parameter int unsigned DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic       iClock,
    input  logic       iReset,
    input  logic       iStopReq,
    input  logic       iStartReq,
    input  logic       iIdle,
    output logic       oClkEn,
    output logic       oStopAck,
    output logic       oStartAck,
    output logic       oTimeout,
    output logic [1:0] oState
);

    localparam logic [CNT_W-1:0] IDLE_TC  = CNT_W'(term_of(IDLE_CYCLES));
    localparam logic [CNT_W-1:0] WAKE_TC  = CNT_W'(term_of(WAKE_CYCLES));
    localparam logic [CNT_W-1:0] DRAIN_TC = CNT_W'(term_of(DRAIN_TIMEOUT));

    gate_state_t state_q, state_d;
    logic        clk_en_q, clk_en_d;
    logic        stop_ack_q, stop_ack_d;
    logic        start_ack_q, start_ack_d;
    logic        timeout_q, timeout_d;

    logic idle_clr, idle_inc, idle_tc;
    logic to_clr, to_inc, to_tc;
    logic wake_clr, wake_inc, wake_tc;

    sat_counter #(.CNT_W(CNT_W)) u_idle_cnt (
        .clk         (iClock),
        .rst         (iReset),
        .clr         (idle_clr),
        .inc         (idle_inc),
        .terminal    (IDLE_TC),
        .at_terminal (idle_tc)
    );

    sat_counter #(.CNT_W(CNT_W)) u_timeout_cnt (
        .clk         (iClock),
        .rst         (iReset),
        .clr         (to_clr),
        .inc         (to_inc),
        .terminal    (DRAIN_TC),
        .at_terminal (to_tc)
    );

    sat_counter #(.CNT_W(CNT_W)) u_wake_cnt (
        .clk         (iClock),
        .rst         (iReset),
        .clr         (wake_clr),
        .inc         (wake_inc),
        .terminal    (WAKE_TC),
        .at_terminal (wake_tc)
    );

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q     <= ST_RUN;
            clk_en_q    <= 1'b1;
            stop_ack_q  <= 1'b0;
            start_ack_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_en_q    <= clk_en_d;
            stop_ack_q  <= stop_ack_d;
            start_ack_q <= start_ack_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        stop_ack_d  = 1'b0;
        start_ack_d = 1'b0;
        timeout_d   = 1'b0;
        idle_clr    = 1'b0;
        idle_inc    = 1'b0;
        to_clr      = 1'b0;
        to_inc      = 1'b0;
        wake_clr    = 1'b0;
        wake_inc    = 1'b0;

        case (state_q)
            ST_RUN: begin
                // Keep drain counters at zero so DRAIN always starts fresh.
                idle_clr = 1'b1;
                to_clr   = 1'b1;
                if (iStopReq) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                idle_inc = iIdle;
                idle_clr = ~iIdle;
                to_inc   = 1'b1;
                // A withdrawn request abandons the drain silently; otherwise
                // a completed idle window beats a simultaneous timeout.
                if (!iStopReq) begin
                    state_d = ST_RUN;
                end else if (iIdle && idle_tc) begin
                    state_d    = ST_STOPPED;
                    stop_ack_d = 1'b1;
                end else if (to_tc) begin
                    state_d   = ST_RUN;
                    timeout_d = 1'b1;
                end
            end

            ST_STOPPED: begin
                wake_clr = 1'b1;
                if (iStartReq) begin
                    state_d = ST_WAKE;
                end
            end

            ST_WAKE: begin
                wake_inc = 1'b1;
                if (wake_tc) begin
                    state_d     = ST_RUN;
                    start_ack_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // CE is a pure function of the next state, registered so the buffer
    // enable comes straight from a flop.
    assign clk_en_d = (state_d != ST_STOPPED);

    assign oClkEn    = clk_en_q;
    assign oStopAck  = stop_ack_q;
    assign oStartAck = start_ack_q;
    assign oTimeout  = timeout_q;
    assign oState    = state_q;

endmodule
